lfsr_rng: RTL
=============

Name: lfsr_rng

Overview:
- Parametrised XNOR Fibonacci LFSR with seed load, free-run stepping and a handshaked bounded-draw engine.
- Supplies game logic with random values in [0, RANGE-1], e.g. arrow lane selection, via rejection sampling.
- Successor to the fixed 10-bit generator. Generalised in width and taps, with lock-up recovery and per-draw decorrelation.

Parameters:
- WIDTH, 10: LFSR state width (>= 3).
- TAP_MASK, 10'b0000001001: state bits that feed the XNOR reduction. The default gives the maximal-length 10-bit sequence (period 1023).
- SEED, 0: value taken on Reset and after lock-up recovery. Must not be all-ones.
- RANGE, 4: draw range; draws return 0..RANGE-1. Requires 2 <= RANGE <= 2**WIDTH.
- MIN_STEPS, 4: minimum LFSR steps per draw (1..15).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- step_en  in  1  advance the LFSR one step per cycle while FSM is IDLE.
- load_valid  in  1  load load_data into the state this cycle.
- load_data  in  WIDTH  seed to load.
- draw_req  in  1  request one bounded draw.
- draw_valid  out  1  draw_data is valid.
- draw_ready  in  1  consumer accepts draw_data.
- draw_data  out  OUT_W  draw result; OUT_W = max(1, clog2(RANGE)).
- state  out  WIDTH  current LFSR register.
- lockup  out  1  one-cycle pulse when the all-ones lock state is recovered.

Behaviour:
- Step function:
  - fb = ~^(state & TAP_MASK), i.e. the XNOR reduction.
  - next = {fb, state[WIDTH-1:1]}, shifting right and inserting at the MSB.
- Reset (synchronous):
  - state = SEED, FSM = IDLE.
  - draw_valid = 0, draw_data = 0, lockup = 0, step counter = 0.
  - Reset mid-draw abandons the draw with no output.
- Update priority per cycle, highest first:
  1. Reset.
  2. load_valid: state <= load_data.
  3. Lock-up: if the update would step from all-ones, state <= SEED instead and lockup = 1 next cycle.
  4. FSM or step_en stepping.
- Loading all-ones is permitted. Recovery happens on the next step attempt.
- FSM states:
  - IDLE:
    - step_en steps the state.
    - draw_req = 1 → SPIN, counter = 0. step_en is ignored in this cycle; SPIN owns the stepping.
  - SPIN:
    - Steps every cycle; counter increments, saturating at MIN_STEPS.
    - Candidate c = low OUT_W bits of the post-step value.
    - Leave SPIN on the step where counter reaches >= MIN_STEPS and c < RANGE. Register draw_data = c, draw_valid = 1, → HOLD.
    - Otherwise stay in SPIN (rejection).
    - step_en is ignored.
  - HOLD:
    - state is frozen; draw_data stays stable while draw_valid = 1.
    - On draw_valid & draw_ready: draw_valid = 0 next cycle, → IDLE.
    - draw_req is ignored until IDLE.
- Latency: minimum MIN_STEPS cycles from draw_req accept to draw_valid. Each rejected candidate adds one cycle.
- Power-of-two RANGE never rejects.
- load_valid during SPIN: the load wins and the counter resets to 0. The draw continues from the loaded value.
- load_valid during HOLD: loads state only; draw_data is unaffected.
- draw_req held high across the handshake yields back-to-back draws, with one IDLE cycle between them.

Optional Feature:
- Macro: LFSR_RNG_PERIOD_EN.
- When defined:
  - Adds output period_cnt [WIDTH-1:0], counting steps since the last Reset or load.
  - Adds output wrapped, a one-cycle pulse when state returns to the value captured at Reset or load.
  - On wrap, period_cnt reports the cycle length and then restarts at 0.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package lfsr_rng_pkg:
  - FSM state enum (IDLE, SPIN, HOLD).
  - Function lfsr_next(state, mask) returning the step result.
  - Default tap-mask constants for widths 8, 10, 16.
- Sub-module lfsr_core: state register, step, load, lock-up recovery. Instantiated by lfsr_rng, which adds the FSM and handshake.

Test Plan:
- Reset, then step_en = 1 for 2 cycles (defaults) → state = 10'h000, 10'h200, 10'h300. After 1023 steps, state returns to 10'h000.
- load_valid with load_data = 10'h3FF, then step_en = 1 → state = SEED (0) and lockup pulses once. No all-ones state persists past one cycle.
- draw_req pulse in IDLE (defaults) → draw_valid rises exactly MIN_STEPS = 4 cycles later. draw_data equals bits [1:0] of state at that point. Value is held while draw_ready = 0 for 5 cycles and drops the cycle after draw_ready = 1.
- RANGE = 3, MIN_STEPS = 1, load 10'h003 then draw → each candidate equal to 3 is rejected. draw_data is never 3 over 500 draws, and all of 0, 1, 2 appear.
- load_valid during SPIN and Reset during HOLD:
  - Load → counter restarts and the draw completes MIN_STEPS cycles after the load.
  - Reset → draw_valid = 0 and state = SEED the next cycle.
- With LFSR_RNG_PERIOD_EN defined, free-run from Reset → wrapped pulses with period_cnt = 1023.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// Shared FSM type, default tap masks and the XNOR Fibonacci step function
// used by the lfsr_rng generator.
package lfsr_rng_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, HOLD} fsm_state_t;

  // Right-shift XNOR taps: bit 0 is the oldest stage.
  localparam logic [7:0]  TAPS_8  = 8'b0001_1101;
  localparam logic [9:0]  TAPS_10 = 10'b00_0000_1001;
  localparam logic [15:0] TAPS_16 = 16'b0001_0000_0000_1011;

  localparam int MAX_W = 64;

  // Callers zero-extend state and mask to MAX_W; width selects the MSB slot.
  function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] state,
                                                 input logic [MAX_W-1:0] mask,
                                                 input int width);
    logic fb;
    fb = ~^(state & mask);
    return (state >> 1) | ({{(MAX_W-1){1'b0}}, fb} << (width - 1));
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed load, stepping and all-ones lock-up recovery.
// Defining LFSR_RNG_PERIOD_EN adds the period_cnt / wrapped cycle-length monitor.
module lfsr_core
  import lfsr_rng_pkg::*;
#(
  parameter int               WIDTH    = 10,
  parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAPS_10),
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter int               CAND_W   = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              step_req,
  output logic [CAND_W-1:0] cand,
  output logic [WIDTH-1:0]  state,
  output logic              lockup
`ifdef LFSR_RNG_PERIOD_EN
  ,
  output logic [WIDTH-1:0]  period_cnt,
  output logic              wrapped
`endif
);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] step_value;
  logic             lockup_reg;
  logic             is_lock;

  // The XNOR form sticks at all-ones, so that step is replaced by the seed.
  assign is_lock    = &state_reg;
  assign step_value = is_lock ? SEED
                              : WIDTH'(lfsr_next(MAX_W'(state_reg), MAX_W'(TAP_MASK), WIDTH));
  assign cand       = step_value[CAND_W-1:0];
  assign state      = state_reg;
  assign lockup     = lockup_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg  <= SEED;
      lockup_reg <= 1'b0;
    end else begin
      lockup_reg <= 1'b0;
      if (load_valid) begin
        state_reg <= load_data;
      end else if (step_req) begin
        state_reg  <= step_value;
        lockup_reg <= is_lock;
      end
    end
  end

`ifdef LFSR_RNG_PERIOD_EN
  logic [WIDTH-1:0] origin_reg;
  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] period_base;
  logic             wrapped_reg;

  // The length is shown for one cycle on wrap, then counting restarts from zero.
  assign period_base = wrapped_reg ? '0 : period_reg;
  assign period_cnt  = period_reg;
  assign wrapped     = wrapped_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      origin_reg  <= SEED;
      period_reg  <= '0;
      wrapped_reg <= 1'b0;
    end else if (load_valid) begin
      origin_reg  <= load_data;
      period_reg  <= '0;
      wrapped_reg <= 1'b0;
    end else if (step_req) begin
      period_reg  <= period_base + WIDTH'(1);
      wrapped_reg <= (step_value == origin_reg);
    end else begin
      period_reg  <= period_base;
      wrapped_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/lfsr_rng.sv
// Bounded random draw engine: LFSR core plus an IDLE/SPIN/HOLD rejection-sampling FSM.
// Defining LFSR_RNG_PERIOD_EN exposes the period_cnt / wrapped ports.
module lfsr_rng
  import lfsr_rng_pkg::*;
#(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(TAPS_10),
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter int               RANGE     = 4,
  parameter int               MIN_STEPS = 4,
  localparam int              OUT_W     = ($clog2(RANGE) > 1) ? $clog2(RANGE) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             step_en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             draw_req,
  output logic             draw_valid,
  input  logic             draw_ready,
  output logic [OUT_W-1:0] draw_data,
  output logic [WIDTH-1:0] state,
  output logic             lockup
`ifdef LFSR_RNG_PERIOD_EN
  ,
  output logic [WIDTH-1:0] period_cnt,
  output logic             wrapped
`endif
);

  localparam logic [3:0]  MIN_CNT = 4'(MIN_STEPS);
  localparam logic [31:0] RANGE_U = 32'(RANGE);

  fsm_state_t       fsm_reg, fsm_next;
  logic [3:0]       cnt_reg, cnt_next, cnt_step;
  logic             valid_reg, valid_next;
  logic [OUT_W-1:0] data_reg, data_next;
  logic [OUT_W-1:0] cand;
  logic             step_req;
  logic             cand_ok;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK),
    .SEED     (SEED),
    .CAND_W   (OUT_W)
  ) u_core (
    .Clock      (Clock),
    .Reset      (Reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .step_req   (step_req),
    .cand       (cand),
    .state      (state),
    .lockup     (lockup)
`ifdef LFSR_RNG_PERIOD_EN
    ,
    .period_cnt (period_cnt),
    .wrapped    (wrapped)
`endif
  );

  assign cand_ok    = (32'(cand) < RANGE_U);
  assign draw_valid = valid_reg;
  assign draw_data  = data_reg;

  always_comb begin
    fsm_next   = fsm_reg;
    cnt_next   = cnt_reg;
    cnt_step   = (cnt_reg >= MIN_CNT) ? cnt_reg : cnt_reg + 4'd1;
    valid_next = valid_reg;
    data_next  = data_reg;
    step_req   = 1'b0;
    case (fsm_reg)
      IDLE: begin
        if (draw_req) begin
          fsm_next = SPIN;
          cnt_next = '0;
        end else begin
          step_req = step_en;
        end
      end
      SPIN: begin
        // A load overrides this cycle's step and restarts the minimum spin.
        if (load_valid) begin
          cnt_next = '0;
        end else begin
          step_req = 1'b1;
          cnt_next = cnt_step;
          if (cnt_step >= MIN_CNT && cand_ok) begin
            valid_next = 1'b1;
            data_next  = cand;
            fsm_next   = HOLD;
          end
        end
      end
      HOLD: begin
        if (draw_ready) begin
          valid_next = 1'b0;
          fsm_next   = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fsm_reg   <= IDLE;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

endmodule
